// File: rtl/rob_commit_ctrl.sv
// -----------------------------------------------------------------------------
// rob_commit_ctrl
//
// Reorder-buffer tag allocator and in-order commit sequencer for a renamed
// register file. Tags are handed out at dispatch (driving the register file's
// rename write), results are captured from the CDB per tag, and entries retire
// strictly in program order, at most one per cycle. Each retirement drives a
// one-cycle pulse on the per-entry ready vector, with that entry's stored data
// and destination on the per-entry buses.
//
// Ports:
//   i_clk             clock
//   i_rst             synchronous active-high reset
//   i_flush           discard every in-flight entry (beats dispatch, CDB, commit)
//   i_dispatch_valid  decoder requests a tag
//   i_dispatch_rd     architectural destination of the dispatching instruction
//   o_dispatch_ready  a tag is available this cycle
//   o_reg_ld_instr    rename write strobe to the register file
//   o_rd_tag          tag being allocated (current tail, zero-extended)
//   o_rd              destination for the rename write
//   i_cdb_valid       result broadcast valid
//   i_cdb_tag         tag of the broadcast result
//   i_cdb_data        broadcast result
//   o_rdy_vec         per-entry commit pulse (one-hot or zero)
//   o_data_vec        per-entry committed data, entry i at [i*Width +: Width]
//   o_rd_bus          per-entry destination, entry i at [i*5 +: 5]
//   o_commit_valid    one entry retired on the previous edge
//   o_commit_tag      tag that retired
//   o_empty           no entries allocated
// -----------------------------------------------------------------------------
module rob_commit_ctrl #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Size     = 8,
  parameter int unsigned TagWidth = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_dispatch_valid,
  input  logic [4:0]            i_dispatch_rd,
  output logic                  o_dispatch_ready,
  output logic                  o_reg_ld_instr,
  output logic [TagWidth-1:0]   o_rd_tag,
  output logic [4:0]            o_rd,
  input  logic                  i_cdb_valid,
  input  logic [TagWidth-1:0]   i_cdb_tag,
  input  logic [Width-1:0]      i_cdb_data,
  output logic [Size-1:0]       o_rdy_vec,
  output logic [Size*Width-1:0] o_data_vec,
  output logic [Size*5-1:0]     o_rd_bus,
  output logic                  o_commit_valid,
  output logic [TagWidth-1:0]   o_commit_tag,
  output logic                  o_empty
);

  localparam int unsigned PtrW   = $clog2(Size);
  localparam int unsigned CountW = PtrW + 1;

  localparam logic [CountW-1:0] FullCount = CountW'(Size);
  localparam logic [CountW-1:0] CountOne  = CountW'(1);
  localparam logic [PtrW-1:0]   PtrOne    = PtrW'(1);

  // Pointer / occupancy state
  logic [PtrW-1:0]   r_head;
  logic [PtrW-1:0]   r_tail;
  logic [CountW-1:0] r_count;

  // Per-entry state
  logic [Size-1:0]   r_valid;
  logic [Size-1:0]   r_done;
  logic [4:0]        r_rd   [Size];
  logic [Width-1:0]  r_data [Size];

  // Registered commit outputs
  logic [Size-1:0]     r_rdy_vec;
  logic                r_commit_valid;
  logic [TagWidth-1:0] r_commit_tag;
  logic                r_empty;

  // Combinational control
  logic              w_full;
  logic              w_dispatch_ready;
  logic              w_dispatch_fire;
  logic [PtrW-1:0]   w_cdb_idx;
  logic              w_cdb_in_range;
  logic              w_cdb_fire;
  logic              w_commit;
  logic [CountW-1:0] w_count_next;

  // ---------------------------------------------------------------------------
  // Dispatch side
  // ---------------------------------------------------------------------------
  // Readiness looks only at the registered count, so a slot freed by a commit
  // on this same edge is not offered until the following cycle.
  assign w_full           = (r_count == FullCount);
  assign w_dispatch_ready = !w_full && !i_flush;
  assign w_dispatch_fire  = i_dispatch_valid && w_dispatch_ready;

  assign o_dispatch_ready = w_dispatch_ready;
  assign o_reg_ld_instr   = w_dispatch_fire;
  assign o_rd_tag         = TagWidth'(r_tail);
  assign o_rd             = i_dispatch_rd;

  // ---------------------------------------------------------------------------
  // CDB capture
  // ---------------------------------------------------------------------------
  assign w_cdb_idx = i_cdb_tag[PtrW-1:0];

  // Tags at or above Size alias onto real entries through the low bits, so
  // they must be rejected explicitly.
  if (TagWidth > PtrW) begin : g_tag_hi
    assign w_cdb_in_range = ~|i_cdb_tag[TagWidth-1:PtrW];
  end else begin : g_tag_fit
    assign w_cdb_in_range = 1'b1;
  end

  // Broadcasts to unallocated entries are dropped.
  assign w_cdb_fire = i_cdb_valid && w_cdb_in_range && r_valid[w_cdb_idx];

  // ---------------------------------------------------------------------------
  // Commit decision
  // ---------------------------------------------------------------------------
  // Uses the registered done bit, so a result captured on edge k retires on
  // edge k+1 at the earliest.
  assign w_commit = r_valid[r_head] && r_done[r_head] && !i_flush;

  always_comb begin
    w_count_next = r_count;
    case ({w_dispatch_fire, w_commit})
      2'b10:   w_count_next = r_count + CountOne;
      2'b01:   w_count_next = r_count - CountOne;
      default: w_count_next = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      r_done         <= '0;
      r_rdy_vec      <= '0;
      r_commit_valid <= 1'b0;
      r_commit_tag   <= '0;
      r_empty        <= 1'b1;
      for (int i = 0; i < Size; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      // Stored data/rd are left as-is; only the bookkeeping is discarded.
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      r_done         <= '0;
      r_rdy_vec      <= '0;
      r_commit_valid <= 1'b0;
      r_commit_tag   <= '0;
      r_empty        <= 1'b1;
    end else begin
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);

      if (w_cdb_fire) begin
        r_done[w_cdb_idx] <= 1'b1;
        r_data[w_cdb_idx] <= i_cdb_data;
      end

      // Commit pulse lasts exactly the one cycle after the retiring edge.
      r_rdy_vec      <= '0;
      r_commit_valid <= w_commit;
      r_commit_tag   <= '0;
      if (w_commit) begin
        r_valid[r_head]   <= 1'b0;
        r_done[r_head]    <= 1'b0;
        r_rdy_vec[r_head] <= 1'b1;
        r_commit_tag      <= TagWidth'(r_head);
        r_head            <= r_head + PtrOne;
      end

      // Placed last so a dispatch overrides any same-slot CDB write above.
      if (w_dispatch_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_rd[r_tail]    <= i_dispatch_rd;
        r_tail          <= r_tail + PtrOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < Size; g++) begin : g_entry_out
    assign o_data_vec[g*Width +: Width] = r_data[g];
    assign o_rd_bus[g*5 +: 5]           = r_rd[g];
  end

  assign o_rdy_vec      = r_rdy_vec;
  assign o_commit_valid = r_commit_valid;
  assign o_commit_tag   = r_commit_tag;
  assign o_empty        = r_empty;

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder-buffer tag allocator and in-order commit sequencer for the renamed register file.
- Hands out ROB tags at dispatch and drives the register file's rename write (busy/tag set).
- Captures CDB results per tag and retires entries strictly in program order.
- Per commit, drives the register file's per-entry ready/data/destination buses for exactly one cycle.

Parameters:
- width, 32, data width of results.
- size, 8, number of ROB entries (power of two).
- tag_width, 4, tag field width; tags are 0..size-1, zero-extended.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all in-flight entries
- dispatch_valid  in  1  decoder requests a tag
- dispatch_rd  in  5  architectural destination of dispatching instruction
- dispatch_ready  out  1  a tag is available this cycle
- reg_ld_instr  out  1  rename write strobe to register file
- rd_tag  out  tag_width  tag being allocated
- rd  out  5  destination for rename write (= dispatch_rd)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  tag_width  tag of broadcast result
- cdb_data  in  width  broadcast result
- rdy_vec  out  size  per-entry commit pulse (rdest[i].rdy)
- data_vec  out  size*width  per-entry committed data (rdest[i].data)
- rd_bus  out  size*5  per-entry architectural destination
- commit_valid  out  1  one entry retired this cycle
- commit_tag  out  tag_width  tag retired
- empty  out  1  no entries allocated

Behaviour:
- State: head, tail (log2(size) bits, wrap mod size); count (0..size); per entry valid, done, rd, data.
- Reset: all state cleared, head=tail=count=0, all outputs 0 except empty=1 and dispatch_ready=1.
- Dispatch:
  - dispatch_ready = (count != size) && !flush; it does not depend on a same-cycle commit.
  - reg_ld_instr = dispatch_valid && dispatch_ready (combinational).
  - rd_tag = tail; rd = dispatch_rd.
  - On the accepting edge: entry[tail] is set to valid=1, done=0, rd=dispatch_rd; tail++.
- CDB:
  - cdb_valid with entry[cdb_tag].valid sets done=1 and data=cdb_data at the edge.
  - CDB to an invalid entry, or cdb_tag >= size: ignored.
  - A CDB and a dispatch to the same tag in one cycle cannot both be legal; dispatch wins.
- Commit:
  - At each edge where entry[head].valid && entry[head].done && !flush: the entry retires.
  - Retirement clears valid and done, advances head, decrements count.
  - It also registers rdy_vec[head]=1, commit_valid=1 and commit_tag=head for the next cycle only.
  - Maximum one commit per cycle.
  - Latency: CDB sampled at edge k; commit at edge k+1; rdy pulse high during the cycle after edge k+1.
  - rdy_vec is one-hot or zero.
  - data_vec[i] and rd_bus[i] hold the entry's stored data and rd. They stay stable through the pulse cycle and until the entry is re-dispatched.
- Simultaneous events:
  - Dispatch plus commit in the same cycle: count unchanged, both pointers advance.
  - When full, a same-cycle commit does not enable dispatch; dispatch is accepted the following cycle.
- rd=0 entries allocate and commit normally. rd_bus carries 0, so the register file ignores the write.
- Flush (priority over dispatch, CDB and commit):
  - At the edge, all valid/done are cleared, head=tail=count=0, and no commit occurs.
  - Next-cycle rdy_vec and commit_valid are 0.
  - data_vec/rd_bus contents are don't-care after flush.
- empty = (count == 0), registered state.
- rst asserted mid-operation behaves like flush and also clears data/rd storage and output registers.

Test Plan:
- Reset then idle: rst high 2 cycles -> empty=1, dispatch_ready=1, rdy_vec=0, commit_valid=0.
- Fill: 8 consecutive dispatches, rd=1..8 -> rd_tag=0..7, reg_ld_instr high 8 cycles; then dispatch_ready=0, and a 9th request gives reg_ld_instr=0.
- Out-of-order completion: CDB tag 2 (0x22), then tag 1 (0x11), then tag 0 (0x00) -> no commit until tag 0 done. Then 3 back-to-back cycles: rdy_vec=0x01, 0x02, 0x04, with data_vec[1]=0x11, data_vec[2]=0x22 and rd_bus entries 1,2,3.
- Wrap-around: after tags 0..7 commit, dispatch 3 more -> rd_tag=0,1,2, head wraps. A CDB to tag 0 commits with commit_tag=0.
- Full plus commit: full ROB with head done, dispatch_valid high -> commit pulse next cycle, dispatch accepted one cycle later with rd_tag=old head.
- Flush: 5 in flight, flush with simultaneous CDB on the head tag and a dispatch -> no rdy pulse and no allocation; next cycle empty=1, first dispatch gets rd_tag=0.
